// File: rtl/tqv_spi_pkg.sv
// Shared SPI controller types: FSM state encoding and bit-counter width.
package tqv_spi_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } spi_state_e;

  localparam int BIT_CNT_W = 3;
endpackage

// File: rtl/tqv_spi_clkdiv.sv
// Half-period timer: down-counter that pulses tick on expiry and reloads itself.
module tqv_spi_clkdiv #(
  parameter int DIV_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [DIV_W-1:0] load_val,
  input  logic             en,
  input  logic [DIV_W-1:0] reload_val,
  output logic             tick
);
  logic [DIV_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (load) begin
      cnt_d = load_val;
    end else if (en) begin
      if (cnt_q == '0) begin
        tick  = 1'b1;
        cnt_d = reload_val;
      end else begin
        cnt_d = cnt_q - DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/tqv_spi_ctrl.sv
// SPI mode-0 byte transmitter with CS/DC control; MISO capture enabled by TQV_SPI_READ_EN.
// state | meaning
// IDLE  | no transfer; start accepted here
// LOW   | SCK low, MOSI holds current bit
// HIGH  | SCK high, MISO sampled on entry
module tqv_spi_ctrl
  import tqv_spi_pkg::*;
#(
  parameter int DIV_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       data_in,
  input  logic             dc_in,
  input  logic             end_txn,
  input  logic [DIV_W-1:0] divider,
  output logic             busy,
  output logic [7:0]       data_out,
  input  logic             spi_miso,
  output logic             spi_cs,
  output logic             spi_sck,
  output logic             spi_mosi,
  output logic             spi_dc
);
  spi_state_e           state_q, state_d;
  logic [BIT_CNT_W-1:0] bit_q, bit_d;
  logic [6:0]           tx_q, tx_d;
  logic                 cs_q, cs_d;
  logic                 mosi_q, mosi_d;
  logic                 dc_q, dc_d;
  logic                 end_q, end_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic                 load, tick, sample, done;

  tqv_spi_clkdiv #(.DIV_W(DIV_W)) u_clkdiv (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .load_val   (divider),
    .en         (busy),
    .reload_val (div_q),
    .tick       (tick)
  );

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    cs_d    = cs_q;
    mosi_d  = mosi_q;
    dc_d    = dc_q;
    end_d   = end_q;
    div_d   = div_q;
    load    = 1'b0;
    sample  = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOW;
          load    = 1'b1;
          bit_d   = '0;
          tx_d    = data_in[6:0];
          mosi_d  = data_in[7];
          cs_d    = 1'b0;
          dc_d    = dc_in;
          end_d   = end_txn;
          div_d   = divider;
        end
      end
      LOW: begin
        if (tick) begin
          state_d = HIGH;
          sample  = 1'b1;
        end
      end
      HIGH: begin
        if (tick) begin
          if (bit_q == '1) begin
            state_d = IDLE;
            done    = 1'b1;
            // CS stays low between bytes of one transaction
            if (end_q) cs_d = 1'b1;
          end else begin
            state_d = LOW;
            bit_d   = bit_q + BIT_CNT_W'(1);
            mosi_d  = tx_q[6];
            tx_d    = {tx_q[5:0], 1'b0};
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bit_q   <= '0;
      tx_q    <= '0;
      cs_q    <= 1'b1;
      mosi_q  <= 1'b0;
      dc_q    <= 1'b0;
      end_q   <= 1'b0;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      cs_q    <= cs_d;
      mosi_q  <= mosi_d;
      dc_q    <= dc_d;
      end_q   <= end_d;
      div_q   <= div_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign spi_sck  = (state_q == HIGH);
  assign spi_cs   = cs_q;
  assign spi_mosi = mosi_q;
  assign spi_dc   = dc_q;

`ifdef TQV_SPI_READ_EN
  logic [7:0] rx_q, rx_d, data_out_q, data_out_d;

  always_comb begin
    rx_d       = rx_q;
    data_out_d = data_out_q;
    if (sample) rx_d = {rx_q[6:0], spi_miso};
    if (done)   data_out_d = rx_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_q       <= '0;
      data_out_q <= '0;
    end else begin
      rx_q       <= rx_d;
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;
`else
  logic unused_rx;
  assign unused_rx = ^{spi_miso, sample, done};
  assign data_out  = '0;
`endif
endmodule

// File: tb/tb_tqv_spi_ctrl.sv
// Randomized self-checking bench for tqv_spi_ctrl against a per-byte transfer model.
module tb_tqv_spi_ctrl;
  localparam int DIV_W = 4;

  logic             clk = 1'b0;
  logic             rst_n, start, dc_in, end_txn, spi_miso;
  logic [7:0]       data_in;
  logic [DIV_W-1:0] divider;
  logic             busy, spi_cs, spi_sck, spi_mosi, spi_dc;
  logic [7:0]       data_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tqv_spi_ctrl #(.DIV_W(DIV_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .data_in  (data_in),
    .dc_in    (dc_in),
    .end_txn  (end_txn),
    .divider  (divider),
    .busy     (busy),
    .data_out (data_out),
    .spi_miso (spi_miso),
    .spi_cs   (spi_cs),
    .spi_sck  (spi_sck),
    .spi_mosi (spi_mosi),
    .spi_dc   (spi_dc)
  );

  // observations of the most recent transfer
  logic       f_busy, f_cs, f_mosi, f_dc;
  logic [7:0] o_mosi, o_miso;
  int         o_len, o_min, o_max;
  logic       o_cs_hi, o_dc_bad, o_timeout;
  logic       r_busy, r_cs, r_sck, r_mosi, r_dc;
  logic [7:0] r_dout;

  function automatic logic [7:0] rd_exp(input logic [7:0] v);
`ifdef TQV_SPI_READ_EN
    return v;
`else
    return 8'h00;
`endif
  endfunction

  // mode: 0 loopback, 1 MISO=1, 2 random MISO, 3 MISO=0
  // dist_kind at cycle dist_c: 1 stray start, 2 divider->7, 3 reset pulse
  task automatic xfer(input logic [7:0] d, input logic dcv, input logic endv,
                      input logic [DIV_W-1:0] div, input int mode,
                      input int dist_c, input int dist_kind);
    int   c, k, run_n;
    logic run_v, prev_sck, prev_mosi, prev_miso;
    data_in = d; dc_in = dcv; end_txn = endv; divider = div; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    f_busy = busy; f_cs = spi_cs; f_mosi = spi_mosi; f_dc = spi_dc;
    c = 1; k = 0; run_v = 1'b0; run_n = 0; o_min = 1 << 30; o_max = 0;
    o_cs_hi = 1'b0; o_dc_bad = 1'b0; o_timeout = 1'b0; o_mosi = '0; o_miso = '0;
    prev_sck = 1'b0; prev_mosi = 1'b0; prev_miso = 1'b0;
    while (busy === 1'b1) begin
      if (c > 2000) begin o_timeout = 1'b1; break; end
      if (spi_cs !== 1'b0) o_cs_hi = 1'b1;
      if (spi_dc !== dcv) o_dc_bad = 1'b1;
      if (spi_sck === run_v) run_n++;
      else begin
        if (run_n < o_min) o_min = run_n;
        if (run_n > o_max) o_max = run_n;
        run_v = spi_sck; run_n = 1;
      end
      if (spi_sck === 1'b1 && prev_sck === 1'b0 && k < 8) begin
        o_mosi[7-k] = prev_mosi; o_miso[7-k] = prev_miso; k++;
      end
      prev_sck = spi_sck; prev_mosi = spi_mosi;
      start = 1'b0;
      case (mode)
        0: spi_miso = spi_mosi;
        1: spi_miso = 1'b1;
        2: spi_miso = 1'($urandom_range(0, 1));
        default: spi_miso = 1'b0;
      endcase
      prev_miso = spi_miso;
      if (c == dist_c) begin
        case (dist_kind)
          1: begin start = 1'b1; data_in = 8'hFF; dc_in = ~dcv; end_txn = ~endv; divider = div + 1'b1; end
          2: divider = 4'd7;
          3: begin
            rst_n = 1'b0; #1;
            r_busy = busy; r_cs = spi_cs; r_sck = spi_sck; r_mosi = spi_mosi; r_dc = spi_dc; r_dout = data_out;
          end
          default: ;
        endcase
      end
      @(negedge clk);
      c++;
    end
    o_len = c - 1;
    if (run_n < o_min) o_min = run_n;
    if (run_n > o_max) o_max = run_n;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; data_in = '0; dc_in = 1'b0; end_txn = 1'b0; divider = '0; spi_miso = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (spi_cs !== 1'b1) begin errors++; $display("FAIL reset_cs got %b exp 1", spi_cs); end
    checks++; if (spi_sck !== 1'b0) begin errors++; $display("FAIL reset_sck got %b exp 0", spi_sck); end
    checks++; if (spi_mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi got %b exp 0", spi_mosi); end
    checks++; if (spi_dc !== 1'b0) begin errors++; $display("FAIL reset_dc got %b exp 0", spi_dc); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_dout got %h exp 00", data_out); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0 || spi_cs !== 1'b1) begin errors++; $display("FAIL post_reset_idle got busy=%b cs=%b exp busy=0 cs=1", busy, spi_cs); end
  endtask

  task automatic test_loopback();
    xfer(8'hA5, 1'b1, 1'b1, 4'd0, 0, 0, 0);
    checks++; if ({f_busy, f_cs, f_mosi, f_dc} !== 4'b1011) begin errors++; $display("FAIL lb_first got busy/cs/mosi/dc=%b%b%b%b exp 1011", f_busy, f_cs, f_mosi, f_dc); end
    checks++; if (o_timeout || o_len != 16) begin errors++; $display("FAIL lb_len got %0d exp 16", o_len); end
    checks++; if (o_mosi !== 8'hA5) begin errors++; $display("FAIL lb_mosi got %h exp a5", o_mosi); end
    checks++; if (o_dc_bad || spi_dc !== 1'b1) begin errors++; $display("FAIL lb_dc got %b exp 1", spi_dc); end
    checks++; if (data_out !== rd_exp(8'hA5)) begin errors++; $display("FAIL lb_dout got %h exp %h", data_out, rd_exp(8'hA5)); end
    checks++; if (spi_cs !== 1'b1 || spi_sck !== 1'b0) begin errors++; $display("FAIL lb_end got cs=%b sck=%b exp cs=1 sck=0", spi_cs, spi_sck); end
    @(negedge clk);
  endtask

  task automatic test_div3();
    xfer(8'h3C, 1'b0, 1'b1, 4'd3, 1, 0, 0);
    checks++; if (o_timeout || o_len != 64) begin errors++; $display("FAIL d3_len got %0d exp 64", o_len); end
    checks++; if (o_min != 4 || o_max != 4) begin errors++; $display("FAIL d3_phase got min=%0d max=%0d exp 4", o_min, o_max); end
    checks++; if (o_mosi !== 8'h3C) begin errors++; $display("FAIL d3_mosi got %h exp 3c", o_mosi); end
    checks++; if (data_out !== rd_exp(8'hFF)) begin errors++; $display("FAIL d3_dout got %h exp %h", data_out, rd_exp(8'hFF)); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    xfer(8'h12, 1'b0, 1'b0, 4'd1, 0, 0, 0);
    checks++; if (o_cs_hi || spi_cs !== 1'b0) begin errors++; $display("FAIL b2b_cs1 got %b exp 0", spi_cs); end
    checks++; if (o_mosi !== 8'h12) begin errors++; $display("FAIL b2b_mosi1 got %h exp 12", o_mosi); end
    xfer(8'h34, 1'b1, 1'b1, 4'd1, 0, 0, 0);
    checks++; if (f_busy !== 1'b1 || f_cs !== 1'b0 || o_cs_hi) begin errors++; $display("FAIL b2b_cs2 got busy=%b cs=%b hi=%b exp 1 0 0", f_busy, f_cs, o_cs_hi); end
    checks++; if (o_mosi !== 8'h34 || o_len != 32) begin errors++; $display("FAIL b2b_byte2 got %h/%0d exp 34/32", o_mosi, o_len); end
    checks++; if (spi_cs !== 1'b1) begin errors++; $display("FAIL b2b_cs_end got %b exp 1", spi_cs); end
    @(negedge clk);
  endtask

  task automatic test_ignored_start();
    xfer(8'h5A, 1'b0, 1'b1, 4'd1, 0, 10, 1);
    checks++; if (o_timeout || o_len != 32) begin errors++; $display("FAIL ign_len got %0d exp 32", o_len); end
    checks++; if (o_mosi !== 8'h5A) begin errors++; $display("FAIL ign_mosi got %h exp 5a", o_mosi); end
    checks++; if (o_dc_bad || spi_cs !== 1'b1) begin errors++; $display("FAIL ign_ctrl got dcbad=%b cs=%b exp 0 1", o_dc_bad, spi_cs); end
    checks++; if (data_out !== rd_exp(8'h5A)) begin errors++; $display("FAIL ign_dout got %h exp %h", data_out, rd_exp(8'h5A)); end
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_idle got %b exp 0", busy); end
  endtask

  task automatic test_div_change();
    xfer(8'hC3, 1'b1, 1'b0, 4'd0, 3, 5, 2);
    checks++; if (o_timeout || o_len != 16 || o_mosi !== 8'hC3) begin errors++; $display("FAIL dch_first got %0d/%h exp 16/c3", o_len, o_mosi); end
    xfer(8'h96, 1'b1, 1'b1, 4'd7, 0, 0, 0);
    checks++; if (o_timeout || o_len != 128) begin errors++; $display("FAIL dch_len got %0d exp 128", o_len); end
    checks++; if (o_min != 8 || o_max != 8 || o_mosi !== 8'h96) begin errors++; $display("FAIL dch_phase got %0d/%0d/%h exp 8/8/96", o_min, o_max, o_mosi); end
    @(negedge clk);
    xfer(8'h69, 1'b0, 1'b1, 4'd15, 1, 0, 0);
    checks++; if (o_timeout || o_len != 256 || o_min != 16 || o_max != 16) begin errors++; $display("FAIL dmax got len=%0d min=%0d max=%0d exp 256/16/16", o_len, o_min, o_max); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    xfer(8'h5A, 1'b1, 1'b0, 4'd1, 2, 17, 3);
    checks++; if ({r_busy, r_cs, r_sck, r_mosi, r_dc} !== 5'b01000) begin errors++; $display("FAIL rmid_outs got busy/cs/sck/mosi/dc=%b%b%b%b%b exp 01000", r_busy, r_cs, r_sck, r_mosi, r_dc); end
    checks++; if (r_dout !== 8'h00) begin errors++; $display("FAIL rmid_dout got %h exp 00", r_dout); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    xfer(8'h81, 1'b0, 1'b1, 4'd1, 0, 0, 0);
    checks++; if ({f_busy, f_cs, f_mosi, f_dc} !== 4'b1010) begin errors++; $display("FAIL rmid_first got %b%b%b%b exp 1010", f_busy, f_cs, f_mosi, f_dc); end
    checks++; if (o_timeout || o_len != 32 || o_mosi !== 8'h81) begin errors++; $display("FAIL rmid_xfer got %0d/%h exp 32/81", o_len, o_mosi); end
    checks++; if (data_out !== rd_exp(8'h81) || spi_cs !== 1'b1) begin errors++; $display("FAIL rmid_end got dout=%h cs=%b exp %h 1", data_out, spi_cs, rd_exp(8'h81)); end
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) begin
      logic [7:0]       d;
      logic             dcv, endv;
      logic [DIV_W-1:0] div;
      d = 8'($urandom); dcv = 1'($urandom); endv = 1'($urandom); div = DIV_W'($urandom_range(0, 3));
      xfer(d, dcv, endv, div, 2, 0, 0);
      checks++; if ({f_busy, f_cs, f_mosi, f_dc} !== {1'b1, 1'b0, d[7], dcv}) begin errors++; $display("FAIL rnd%0d_first got %b%b%b%b exp 10%b%b", i, f_busy, f_cs, f_mosi, f_dc, d[7], dcv); end
      checks++; if (o_timeout || o_len != 16 * (int'(div) + 1)) begin errors++; $display("FAIL rnd%0d_len got %0d exp %0d", i, o_len, 16 * (int'(div) + 1)); end
      checks++; if (o_mosi !== d || o_dc_bad) begin errors++; $display("FAIL rnd%0d_mosi got %h dcbad=%b exp %h", i, o_mosi, o_dc_bad, d); end
      checks++; if (data_out !== rd_exp(o_miso)) begin errors++; $display("FAIL rnd%0d_dout got %h exp %h", i, data_out, rd_exp(o_miso)); end
      checks++; if (spi_cs !== endv || spi_sck !== 1'b0 || spi_dc !== dcv) begin errors++; $display("FAIL rnd%0d_end got cs=%b sck=%b dc=%b exp %b 0 %b", i, spi_cs, spi_sck, spi_dc, endv, dcv); end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_div3();
    test_back_to_back();
    test_ignored_start();
    test_div_change();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
